stopwatch_ctrl: RTL

//  Central sequencer for the stopwatch datapath: turns two debounced push-button levels
//  (start/stop, lap/reset) into count-enable, counter-clear, lap-capture and display-hold controls.

---
 rtl/stopwatch_ctrl_pkg.sv | 15 +
 rtl/stopwatch_ctrl_btn_press_timer.sv | 68 ++++++
 rtl/stopwatch_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer: state encodings and
// default press-timing parameters.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_e;

   localparam int LONG_TICKS_DEF = 200;
   localparam int TW_DEF         = 8;

endpackage

// File: rtl/stopwatch_ctrl_btn_press_timer.sv
// Classifies one debounced button level into single-clk short/long press pulses
// using an edge detector and a tick-driven saturating hold timer.
module btn_press_timer
   import stopwatch_ctrl_pkg::*;
#(
   parameter int LONG_TICKS = LONG_TICKS_DEF,
   parameter int TW         = TW_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn,
   output logic short_evt,
   output logic long_evt
);

   localparam logic [TW-1:0] LONG_T = TW'(LONG_TICKS);

   logic          btn_q;
   logic          armed_q, armed_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          short_q, short_d;
   logic          long_q, long_d;
   logic          rise, fall;

   assign rise = btn & ~btn_q;
   assign fall = ~btn & btn_q;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      timer_d = timer_q;
      armed_d = armed_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      if (rise) begin
         timer_d = '0;
         armed_d = 1'b1;
      end else if (fall) begin
         armed_d = 1'b0;
         short_d = armed_q && (timer_q < LONG_T);
      end else if (btn && armed_q && tick && (timer_q < LONG_T)) begin
         timer_d = timer_q + TW'(1);
         long_d  = (timer_d == LONG_T);
      end
   end

   // NOTE: btn_q resets to 1 so a button held through reset shows no rising edge; armed_q
   // stays 0 until a genuine press starts, so its eventual release is ignored too.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q   <= 1'b1;
         armed_q <= 1'b0;
         timer_q <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         btn_q   <= btn;
         armed_q <= armed_d;
         timer_q <= timer_d;
         short_q <= short_d;
         long_q  <= long_d;
      end
   end

   assign short_evt = short_q;
   assign long_evt  = long_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: arbitrates start/stop and lap/reset press events into
// count-enable, clear, lap-capture and display-hold controls.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int LONG_TICKS = LONG_TICKS_DEF,
   parameter int TW         = TW_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       count_enable,
   output logic       count_clr,
   output logic       lap_capture,
   output logic       disp_hold,
   output logic [1:0] state
);

   sw_state_e state_q, state_d;
   logic      clr_q, clr_d;
   logic      cap_q, cap_d;
   logic      start_short, start_long, lap_short, lap_long;

   btn_press_timer #(.LONG_TICKS(LONG_TICKS), .TW(TW)) u_start_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .btn       (btn_start),
      .short_evt (start_short),
      .long_evt  (start_long)
   );

   btn_press_timer #(.LONG_TICKS(LONG_TICKS), .TW(TW)) u_lap_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .btn       (btn_lap),
      .short_evt (lap_short),
      .long_evt  (lap_long)
   );

   // Priority: any long press, then start short, then lap short; losers are dropped.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      cap_d   = 1'b0;
      if (start_long || lap_long) begin
         state_d = ST_IDLE;
         clr_d   = 1'b1;
      end else if (start_short) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            ST_LAP:   state_d = ST_PAUSE;
            default:  state_d = ST_IDLE;
         endcase
      end else if (lap_short) begin
         case (state_q)
            ST_RUN: begin
               state_d = ST_LAP;
               cap_d   = 1'b1;
            end
            ST_LAP:   state_d = ST_RUN;
            ST_PAUSE: begin
               state_d = ST_IDLE;
               clr_d   = 1'b1;
            end
            default:  state_d = state_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         clr_q   <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         cap_q   <= cap_d;
      end
   end

   assign count_enable = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign disp_hold    = (state_q == ST_LAP);
   assign count_clr    = clr_q;
   assign lap_capture  = cap_q;
   assign state        = state_q;

endmodule
